// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its consumers.
// The ID stage imports ifid_t to decode the IF/ID register contents.
package if_pkg;

  // Default program-counter width in bits (byte address, word aligned)
  localparam int PC_W_DEF = 9;

  // Bubble word loaded into IF/ID on reset and on flush: addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // IF/ID register contents. The pc field is carried at full 32-bit width
  // so the type is independent of the PC_W chosen by any instance.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  // Bubble value of the IF/ID register
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.pc    = '0;
    b.instr = NOP_INSTR;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its environment (branch unit,
// hazard unit, instruction memory, ID stage).
// The perf_* signals exist only when IF_PERF_CNT_EN is defined.
interface if_stage_if import if_pkg::*; #(
  parameter int PC_W = PC_W_DEF
);
  logic            stall;
  logic            pc_sel;
  logic [31:0]     br_pc;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_redirects;
  logic [31:0]     perf_stalls;
`endif

  // Environment side: drives control and memory data, observes fetch outputs
  modport master (
    output stall, pc_sel, br_pc, instr_i,
`ifdef IF_PERF_CNT_EN
    input  perf_redirects, perf_stalls,
`endif
    input  pc_o, ifid_pc, ifid_instr, ifid_valid
  );

  // Fetch-stage side
  modport slave (
    input  stall, pc_sel, br_pc, instr_i,
`ifdef IF_PERF_CNT_EN
    output perf_redirects, perf_stalls,
`endif
    output pc_o, ifid_pc, ifid_instr, ifid_valid
  );
endinterface

// File: rtl/if_stage_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: increment unless already saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Priority for both PC and IF/ID: reset > redirect (pc_sel) > stall > fetch.
// Optional feature macro: IF_PERF_CNT_EN adds redirect/stall counters.
// PC_W must be in 3..31.
module if_stage import if_pkg::*; #(
  parameter int          PC_W      = PC_W_DEF,
  parameter logic [31:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic           clk,
  input  logic           reset,
  if_stage_if.slave      bus
);
  logic [PC_W-1:0] pc_q, pc_d;
  ifid_t           ifid_q, ifid_d;
  ifid_t           bubble;
  logic [PC_W-1:0] br_tgt;

  always_comb begin
    bubble       = ifid_bubble();
    bubble.instr = NOP_INSTR;
  end

  // Redirect target: out-of-range upper bits dropped, word-aligned
  assign br_tgt = {bus.br_pc[PC_W-1:2], 2'b00};

  // Next PC
  always_comb begin
    pc_d = pc_q + PC_W'(4);
    if (bus.pc_sel)     pc_d = br_tgt;
    else if (bus.stall) pc_d = pc_q;
  end

  // Next IF/ID: a redirect squashes the wrong-path word even under stall,
  // since the redirecting branch is older than the stalling instruction
  always_comb begin
    ifid_d       = ifid_q;
    if (bus.pc_sel) begin
      ifid_d = bubble;
    end else if (!bus.stall) begin
      ifid_d.pc    = 32'(pc_q);
      ifid_d.instr = bus.instr_i;
      ifid_d.valid = 1'b1;
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= '0;
      ifid_q <= bubble;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign bus.pc_o       = pc_q;
  assign bus.ifid_pc    = ifid_q.pc[PC_W-1:0];
  assign bus.ifid_instr = ifid_q.instr;
  assign bus.ifid_valid = ifid_q.valid;

  // Bits of br_pc and of the widened pc field that never reach state
  logic unused_bits;
  assign unused_bits = ^{bus.br_pc[31:PC_W], bus.br_pc[1:0], ifid_q.pc[31:PC_W]};

`ifdef IF_PERF_CNT_EN
  logic stall_cnt_inc;
  assign stall_cnt_inc = bus.stall & ~bus.pc_sel;

  sat_counter #(.W(32)) u_redirect_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc_i (bus.pc_sel),
    .cnt_o (bus.perf_redirects)
  );

  sat_counter #(.W(32)) u_stall_cnt (
    .clk   (clk),
    .rst   (reset),
    .inc_i (stall_cnt_inc),
    .cnt_o (bus.perf_stalls)
  );
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Memory returns word = address ^ 32'hA5A5_0000.
module tb_if_stage;
  localparam int PC_W = 9;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic reset;
  int   n_asserts = 0;
  int   n_fail    = 0;

  if_stage_if #(.PC_W(PC_W)) bus();

  if_stage #(.PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory
  assign bus.instr_i = {23'b0, bus.pc_o} ^ KEY;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic valid);
    check({tag, ".ifid_pc"},    32'(bus.ifid_pc), pc);
    check({tag, ".ifid_instr"}, bus.ifid_instr,   instr);
    check({tag, ".ifid_valid"}, 32'(bus.ifid_valid), 32'(valid));
  endtask

  task automatic redirect(input logic [31:0] tgt);
    bus.pc_sel = 1'b1;
    bus.br_pc  = tgt;
    step();
    bus.pc_sel = 1'b0;
  endtask

`ifdef IF_PERF_CNT_EN
  logic [31:0] stalls0;
`endif

  initial begin
    reset      = 1'b1;
    bus.stall  = 1'b0;
    bus.pc_sel = 1'b0;
    bus.br_pc  = '0;
    step();
    step();
    // Reset state
    check("rst.pc_o", 32'(bus.pc_o), 32'h0);
    check_ifid("rst", 32'h0, NOP, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("rst.perf_redirects", bus.perf_redirects, 32'h0);
    check("rst.perf_stalls",    bus.perf_stalls,    32'h0);
`endif

    // Release and fetch sequentially: pcs 0, 4, 8 appear in IF/ID
    @(negedge clk);
    reset = 1'b0;
    step();
    check("seq0.pc_o", 32'(bus.pc_o), 32'h4);
    check_ifid("seq0", 32'h0, 32'hA5A5_0000, 1'b1);
    step();
    check_ifid("seq1", 32'h4, 32'hA5A5_0004, 1'b1);
    step();
    check_ifid("seq2", 32'h8, 32'hA5A5_0008, 1'b1);
    check("seq2.pc_o", 32'(bus.pc_o), 32'hC);
    step();
    check("seq3.pc_o", 32'(bus.pc_o), 32'h10);

    // Redirect to 0x40 from PC=0x10: one bubble, then target word
    redirect(32'h0000_0040);
    check("br40.pc_o", 32'(bus.pc_o), 32'h40);
    check_ifid("br40.bubble", 32'h0, NOP, 1'b0);
    step();
    check_ifid("br40.tgt", 32'h40, 32'hA5A5_0040, 1'b1);
    check("br40.pc_next", 32'(bus.pc_o), 32'h44);

    // Get to PC=0x20 with 0x1C held in IF/ID, then stall 3 cycles
    redirect(32'h0000_001C);
    step();
    check("pre_stall.pc_o", 32'(bus.pc_o), 32'h20);
`ifdef IF_PERF_CNT_EN
    stalls0 = bus.perf_stalls;
`endif
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall.pc_o", 32'(bus.pc_o), 32'h20);
      check_ifid("stall", 32'h1C, 32'hA5A5_001C, 1'b1);
    end
    bus.stall = 1'b0;
`ifdef IF_PERF_CNT_EN
    check("stall.perf_delta", bus.perf_stalls - stalls0, 32'd3);
`endif
    step();
    check("resume.pc_o", 32'(bus.pc_o), 32'h24);
    check_ifid("resume", 32'h20, 32'hA5A5_0020, 1'b1);

    // Stall and redirect together: redirect wins, IF/ID flushed
    bus.stall = 1'b1;
    redirect(32'h0000_0084);
    bus.stall = 1'b0;
    check("stbr.pc_o", 32'(bus.pc_o), 32'h84);
    check_ifid("stbr", 32'h0, NOP, 1'b0);

    // Back-to-back redirects: last target wins, still a bubble
    bus.pc_sel = 1'b1;
    bus.br_pc  = 32'h0000_0100;
    step();
    bus.br_pc  = 32'h0000_0180;
    step();
    bus.pc_sel = 1'b0;
    check("b2b.pc_o", 32'(bus.pc_o), 32'h180);
    check_ifid("b2b", 32'h0, NOP, 1'b0);
    step();
    check_ifid("b2b.tgt", 32'h180, 32'hA5A5_0180, 1'b1);

    // Unaligned, out-of-range target
    redirect(32'hFFFF_FE07);
    check("unal.pc_o", 32'(bus.pc_o), 32'h004);

    // Sequential wrap from 0x1FC
    redirect(32'h0000_01FC);
    check("wrap.pre", 32'(bus.pc_o), 32'h1FC);
    step();
    check("wrap.pc_o", 32'(bus.pc_o), 32'h000);
    check_ifid("wrap", 32'h1FC, 32'hA5A5_01FC, 1'b1);
`ifdef IF_PERF_CNT_EN
    // Redirects: 0x40, 0x1C, 0x84, 0x100, 0x180, 0x...E07, 0x1FC
    check("perf_redirects", bus.perf_redirects, 32'd7);
`endif

    // Asynchronous reset pulse mid-cycle while fetching at 0x30
    redirect(32'h0000_002C);
    step();
    check("arst.pre", 32'(bus.pc_o), 32'h30);
    #2 reset = 1'b1;
    #1;
    check("arst.pc_o", 32'(bus.pc_o), 32'h0);
    check_ifid("arst", 32'h0, NOP, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("arst.perf_redirects", bus.perf_redirects, 32'h0);
    check("arst.perf_stalls",    bus.perf_stalls,    32'h0);
`endif
    #1 reset = 1'b0;
    step();
    check("post.pc_o", 32'(bus.pc_o), 32'h4);
    check_ifid("post", 32'h0, 32'hA5A5_0000, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline: owns the program counter and the IF/ID pipeline register. Each cycle it presents the PC to instruction memory and captures the returned word into IF/ID. It consumes the branch unit's redirect (select plus target, resolved in EX) and the hazard unit's stall. A taken redirect overrides sequential fetch and squashes the wrong-path word held in IF/ID.

## Interface
Parameters:
- PC_W, 9: program counter width in bits; byte address, word aligned.
- NOP_INSTR, 32'h0000_0013: bubble word (`addi x0,x0,0`) loaded into IF/ID on reset and flush.

Ports:
- clk  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hazard-unit load-use stall; hold PC and IF/ID.
- pc_sel  in  1  branch unit: redirect taken this cycle.
- br_pc  in  32  branch unit: redirect target.
- instr_i  in  32  instruction memory read data for pc_o; combinational, same cycle.
- pc_o  out  PC_W  current fetch address to instruction memory.
- ifid_pc  out  PC_W  PC of the word held in IF/ID.
- ifid_instr  out  32  instruction held in IF/ID.
- ifid_valid  out  1  1 = real instruction, 0 = bubble.
- perf_redirects  out  32  redirect count (only with IF_PERF_CNT_EN).
- perf_stalls  out  32  stalled-cycle count (only with IF_PERF_CNT_EN).

## Operation
- Next-PC priority, highest first: reset, then pc_sel, then stall, then sequential.
  - pc_sel=1: PC ← {br_pc[PC_W-1:2], 2'b00}. Upper bits of br_pc are dropped and low two bits forced to zero.
  - stall=1 (pc_sel=0): PC holds.
  - Otherwise: PC ← PC + 4, modulo 2^PC_W. Wrap from 2^PC_W−4 to 0 is silent.
- IF/ID update, same priority:
  - pc_sel=1: flush. ifid_instr ← NOP_INSTR, ifid_valid ← 0, ifid_pc ← 0. The redirect is older than any stalling instruction, so it wins when both are asserted.
  - stall=1: all IF/ID fields hold.
  - Otherwise: ifid_pc ← PC, ifid_instr ← instr_i, ifid_valid ← 1.
- pc_o is the PC register output directly; no combinational path from any input to pc_o.
- Flushing ID/EX is not done here; the hazard unit uses pc_sel for that.

## Timing
- Reset values while reset is high: PC=0, ifid_pc=0, ifid_instr=NOP_INSTR, ifid_valid=0, both perf counters 0.
- Reset asserted mid-operation clears all state immediately, with no clock edge needed.
- Fetch latency is one cycle: the word at pc_o in cycle N appears on ifid_* in cycle N+1.
- First edge after reset release: IF/ID ← {pc 0, instr_i, valid 1}, PC ← 4.
- Redirect at edge N: pc_o = target in cycle N+1; the target's word is valid in IF/ID in cycle N+2. Exactly one bubble appears in IF/ID.
- Back-to-back pc_sel on consecutive cycles: each one redirects and flushes; the last target wins.
- Stall held for k cycles: PC and IF/ID are frozen for k edges; fetch resumes on the first edge with stall=0.

## Configuration
- IF_PERF_CNT_EN defined:
  - perf_redirects increments on every edge with pc_sel=1.
  - perf_stalls increments on every edge with stall=1 and pc_sel=0.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- IF_PERF_CNT_EN undefined:
  - Counter logic and both perf_* ports are absent.
  - All other behaviour is identical.

## Structure
- Shared package if_pkg:
  - NOP_INSTR constant.
  - Default PC_W.
  - Typedef ifid_t, a struct of {pc, instr, valid}. The ID stage imports it.
- One sub-module, sat_counter, parameterised by width, with inc and asynchronous reset. It is instantiated twice, only under IF_PERF_CNT_EN.

## Test plan
- Reset, then release with memory returning word = address ^ 32'hA5A5_0000:
  - IF/ID shows pcs 0, 4, 8 on consecutive cycles with matching words and valid=1.
  - Before release, ifid_instr = 32'h13 and valid=0.
- pc_sel=1, br_pc=32'h0000_0040 while PC=0x10:
  - Next cycle pc_o=0x40 and IF/ID is a bubble (valid 0, NOP).
  - Following cycle ifid_pc=0x40.
- stall=1 for 3 cycles at PC=0x20:
  - pc_o stays 0x20 and IF/ID holds its contents.
  - perf_stalls increases by 3 when IF_PERF_CNT_EN is defined.
- stall=1 and pc_sel=1 with br_pc=0x84 in the same cycle: PC becomes 0x84 and IF/ID is flushed.
- Unaligned and out-of-range target, br_pc=32'hFFFF_FE07 with PC_W=9: PC becomes 0x004.
- Sequential wrap from PC=0x1FC: next PC is 0x000.
- Asynchronous reset pulse mid-cycle while fetching at 0x30: all outputs hit reset values before the next clock edge.
